load_store_unit: RTL and testbench

//  Downstream of the ALU in the execute/memory path: takes ALUout as the effective address
//  and RegOp2 as store data, and runs one LB/LH/LW/LBU/LHU/SB/SH/SW per request.

---
 rtl/load_store_unit.sv | 241 ++++++++++++++++++++++++
 tb/tb_load_store_unit.sv | 361 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/load_store_unit.sv
// load_store_unit: one RV32I load or store per request, bridged onto a
// valid/ready data-memory channel with a separate read-response strobe.
// Decodes and checks the request at accept time, places store bytes on the
// correct lanes, and extracts and extends load data into a one-cycle response.
module load_store_unit #(
  parameter int unsigned MAX_WAIT = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        mem_valid,
  input  logic        mem_ready,
  output logic [31:0] mem_addr,
  output logic        mem_we,
  output logic [3:0]  mem_be,
  output logic [31:0] mem_wdata,
  input  logic        mem_rvalid,
  input  logic [31:0] mem_rdata,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_fault,
  output logic        busy
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_REQ  = 2'd1;
  localparam logic [1:0] ST_WAIT = 2'd2;
  localparam logic [1:0] ST_DONE = 2'd3;

  // Counter value seen on the last permitted cycle in REQ or WAIT.
  localparam logic [7:0] LAST_CNT = 8'(MAX_WAIT - 1);

  // funct3 encodings (size in [1:0], unsigned flag in [2])
  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  // FSM and captured-operation state
  logic [1:0]  state_reg, state_next;
  logic [7:0]  cnt_reg, cnt_next;
  logic        we_reg;
  logic [2:0]  funct3_reg;
  logic [1:0]  offset_reg;
  logic [31:0] addr_reg;
  logic [3:0]  be_reg;
  logic [31:0] wdata_reg;
  logic [31:0] rdata_reg;
  logic        fault_reg;

  // Request decode
  logic        funct3_ok;
  logic        misaligned;
  logic        accept_fault;
  logic        accept;
  logic [3:0]  lane_be;
  logic [31:0] lane_wdata;

  // Progress / timeout
  logic        cnt_last;
  logic        timeout;

  // Load extraction
  logic [7:0]  rd_byte [4];
  logic [7:0]  sel_byte;
  logic [15:0] sel_half;
  logic [31:0] load_value;

  assign accept   = req_valid && (state_reg == ST_IDLE);
  assign cnt_last = (cnt_reg == LAST_CNT);

  // Legal funct3 check: stores allow B/H/W only, loads also allow BU/HU.
  always_comb begin
    funct3_ok = 1'b0;
    if (req_we) begin
      funct3_ok = (req_funct3 == F3_B) || (req_funct3 == F3_H) ||
                  (req_funct3 == F3_W);
    end else begin
      funct3_ok = (req_funct3 == F3_B)  || (req_funct3 == F3_H)  ||
                  (req_funct3 == F3_W)  || (req_funct3 == F3_BU) ||
                  (req_funct3 == F3_HU);
    end
  end

  // Natural-alignment check based on the access size in funct3[1:0].
  always_comb begin
    misaligned = 1'b0;
    case (req_funct3[1:0])
      2'b01:   misaligned = req_addr[0];
      2'b10:   misaligned = |req_addr[1:0];
      default: misaligned = 1'b0;
    endcase
  end

  assign accept_fault = !funct3_ok || misaligned;

  // Store lane placement; data is replicated so every enabled lane sees it.
  always_comb begin
    lane_be    = 4'b1111;
    lane_wdata = req_wdata;
    case (req_funct3[1:0])
      2'b00: begin
        lane_be    = 4'b0001 << req_addr[1:0];
        lane_wdata = {4{req_wdata[7:0]}};
      end
      2'b01: begin
        lane_be    = req_addr[1] ? 4'b1100 : 4'b0011;
        lane_wdata = {2{req_wdata[15:0]}};
      end
      default: begin
        lane_be    = 4'b1111;
        lane_wdata = req_wdata;
      end
    endcase
  end

  // Split the read word into byte lanes so the byte offset can index them.
  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_rd_lane
      assign rd_byte[gi] = mem_rdata[8*gi +: 8];
    end
  endgenerate

  assign sel_byte = rd_byte[offset_reg];
  assign sel_half = offset_reg[1] ? mem_rdata[31:16] : mem_rdata[15:0];

  // Align and sign/zero-extend the returned word for the captured load type.
  always_comb begin
    load_value = 32'd0;
    case (funct3_reg)
      F3_B:    load_value = {{24{sel_byte[7]}}, sel_byte};
      F3_H:    load_value = {{16{sel_half[15]}}, sel_half};
      F3_W:    load_value = mem_rdata;
      F3_BU:   load_value = {24'd0, sel_byte};
      F3_HU:   load_value = {16'd0, sel_half};
      default: load_value = 32'd0;
    endcase
  end

  // Next state and wait counter; progress beats timeout on the last cycle.
  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    timeout    = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        cnt_next = 8'd0;
        if (req_valid) begin
          state_next = accept_fault ? ST_DONE : ST_REQ;
        end
      end
      ST_REQ: begin
        if (mem_ready) begin
          state_next = we_reg ? ST_DONE : ST_WAIT;
          cnt_next   = 8'd0;
        end else if (cnt_last) begin
          state_next = ST_DONE;
          timeout    = 1'b1;
        end else begin
          cnt_next = cnt_reg + 8'd1;
        end
      end
      ST_WAIT: begin
        if (mem_rvalid) begin
          state_next = ST_DONE;
        end else if (cnt_last) begin
          state_next = ST_DONE;
          timeout    = 1'b1;
        end else begin
          cnt_next = cnt_reg + 8'd1;
        end
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  // State register; reset abandons any open operation immediately.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= ST_IDLE;
      cnt_reg   <= 8'd0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
    end
  end

  // Capture the operation at accept; it stays frozen while the request is open.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      we_reg     <= 1'b0;
      funct3_reg <= 3'b000;
      offset_reg <= 2'b00;
      addr_reg   <= 32'd0;
      be_reg     <= 4'b0000;
      wdata_reg  <= 32'd0;
    end else if (accept) begin
      we_reg     <= req_we;
      funct3_reg <= req_funct3;
      offset_reg <= req_addr[1:0];
      addr_reg   <= {req_addr[31:2], 2'b00};
      be_reg     <= req_we ? lane_be : 4'b1111;
      wdata_reg  <= req_we ? lane_wdata : 32'd0;
    end
  end

  // Response data and fault flag; both clear at accept so stores/faults return 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdata_reg <= 32'd0;
      fault_reg <= 1'b0;
    end else if (accept) begin
      rdata_reg <= 32'd0;
      fault_reg <= accept_fault;
    end else if ((state_reg == ST_WAIT) && mem_rvalid) begin
      rdata_reg <= load_value;
    end else if (timeout) begin
      fault_reg <= 1'b1;
    end
  end

  assign req_ready = (state_reg == ST_IDLE);
  assign busy      = (state_reg != ST_IDLE);
  assign mem_valid = (state_reg == ST_REQ);
  assign mem_addr  = addr_reg;
  assign mem_we    = mem_valid && we_reg;
  assign mem_be    = mem_valid ? be_reg : 4'b0000;
  assign mem_wdata = wdata_reg;
  assign rsp_valid = (state_reg == ST_DONE);
  assign rsp_rdata = rdata_reg;
  assign rsp_fault = rsp_valid && fault_reg;

endmodule

// File: tb/tb_load_store_unit.sv
// tb_load_store_unit: directed and randomized checks of load_store_unit
// against a byte-addressed reference memory and plain latency arithmetic.
module tb_load_store_unit;

  localparam int unsigned MAX_WAIT = 4;
  localparam int NEVER = 99;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_we = 1'b0;
  logic [2:0]  req_funct3 = 3'b000;
  logic [31:0] req_addr = 32'd0;
  logic [31:0] req_wdata = 32'd0;
  logic        mem_valid;
  logic        mem_ready = 1'b0;
  logic [31:0] mem_addr;
  logic        mem_we;
  logic [3:0]  mem_be;
  logic [31:0] mem_wdata;
  logic        mem_rvalid = 1'b0;
  logic [31:0] mem_rdata = 32'd0;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_fault;
  logic        busy;

  int n_checks = 0;
  int n_fail = 0;

  // Memory seen by the DUT (words) and the reference view (bytes), 0x100..0x11F
  logic [31:0] mem_words [8];
  logic [7:0]  ref_bytes [32];

  load_store_unit #(.MAX_WAIT(MAX_WAIT)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
    .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_addr(mem_addr),
    .mem_we(mem_we), .mem_be(mem_be), .mem_wdata(mem_wdata),
    .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_fault(rsp_fault),
    .busy(busy)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  task automatic set_word(input int idx, input logic [31:0] w);
    mem_words[idx] = w;
    for (int b = 0; b < 4; b++) ref_bytes[idx*4 + b] = 8'((w >> (8*b)) & 32'hFF);
  endtask

  function automatic int access_size(input logic [2:0] f3);
    return 1 << f3[1:0];
  endfunction

  function automatic logic expect_fault(input logic we, input logic [2:0] f3, input logic [31:0] addr);
    logic legal;
    legal = we ? (f3 <= 3'd2) : ((f3 <= 3'd2) || (f3 == 3'd4) || (f3 == 3'd5));
    if (!legal) return 1'b1;
    return (addr % access_size(f3)) != 0;
  endfunction

  function automatic logic [31:0] ref_load(input logic [2:0] f3, input logic [31:0] addr);
    logic [31:0] v;
    int n;
    n = access_size(f3);
    v = 32'd0;
    for (int k = 0; k < n; k++) v = v | (32'(ref_bytes[(int'(addr[4:0]) + k) % 32]) << (8*k));
    if (!f3[2] && n < 4 && v[8*n-1]) v = v | ~((32'h1 << (8*n)) - 32'h1);
    return v;
  endfunction

  task automatic ref_store(input logic [2:0] f3, input logic [31:0] addr, input logic [31:0] wd);
    for (int k = 0; k < access_size(f3); k++)
      ref_bytes[(int'(addr[4:0]) + k) % 32] = 8'((wd >> (8*k)) & 32'hFF);
  endtask

  // Issue one operation and act as the memory; returns what the response carried.
  task automatic run_op(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                        input logic [31:0] wd, input int rdy_dly, input int rv_dly,
                        output logic [31:0] rdata, output logic fault, output int lat,
                        output logic [31:0] hs_addr, output logic [3:0] hs_be,
                        output logic [31:0] hs_wdata, output logic saw_mem);
    int req_cnt, wait_cnt;
    logic hs, done;
    rdata = 32'd0; fault = 1'b0; lat = -1;
    hs_addr = 32'd0; hs_be = 4'd0; hs_wdata = 32'd0; saw_mem = 1'b0;
    req_cnt = 0; wait_cnt = 0; hs = 1'b0; done = 1'b0;
    @(negedge clk);
    n_checks++;
    if (rsp_valid !== 1'b0 || req_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL idle_entry: rsp_valid=%b req_ready=%b expected 0/1", rsp_valid, req_ready);
    end
    req_valid = 1'b1; req_we = we; req_funct3 = f3; req_addr = addr; req_wdata = wd;
    mem_ready = 1'b0; mem_rvalid = 1'b0;
    for (int c = 1; c <= 40 && !done; c++) begin
      @(negedge clk);
      mem_ready = 1'b0; mem_rvalid = 1'b0; mem_rdata = $urandom;
      if (rsp_valid === 1'b1) begin
        lat = c; rdata = rsp_rdata; fault = rsp_fault; done = 1'b1;
      end else begin
        n_checks++;
        if (busy !== 1'b1 || req_ready !== 1'b0) begin
          n_fail++;
          $display("FAIL busy_hold: busy=%b req_ready=%b expected 1/0", busy, req_ready);
        end
        if (mem_valid === 1'b1) begin
          if (!saw_mem) begin
            saw_mem = 1'b1; hs_addr = mem_addr; hs_be = mem_be; hs_wdata = mem_wdata;
            n_checks++;
            if (mem_we !== we) begin
              n_fail++;
              $display("FAIL mem_we: got %b expected %b", mem_we, we);
            end
          end else begin
            n_checks++;
            if (mem_addr !== hs_addr || mem_be !== hs_be || mem_wdata !== hs_wdata) begin
              n_fail++;
              $display("FAIL req_stable: got %h/%b/%h expected %h/%b/%h",
                       mem_addr, mem_be, mem_wdata, hs_addr, hs_be, hs_wdata);
            end
          end
          mem_rvalid = 1'($urandom_range(0, 1));
          if (req_cnt == rdy_dly) begin
            mem_ready = 1'b1; hs = 1'b1;
            if (we) begin
              for (int i = 0; i < 4; i++)
                if (mem_be[i]) mem_words[mem_addr[4:2]][8*i +: 8] = mem_wdata[8*i +: 8];
            end
          end
          req_cnt++;
        end else if (hs && !we) begin
          if (wait_cnt == rv_dly) begin
            mem_rvalid = 1'b1; mem_rdata = mem_words[addr[4:2]];
          end
          wait_cnt++;
        end
      end
    end
    req_valid = 1'b0;
    n_checks++;
    if (!done) begin
      n_fail++;
      $display("FAIL rsp_timeout: no rsp_valid within 40 cycles, expected a response");
    end
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    n_checks++;
    if ({req_ready, mem_valid, mem_we, mem_be, rsp_valid, rsp_fault, busy} !== 10'b10_0000_0000) begin
      n_fail++;
      $display("FAIL reset_ctrl: got %b%b%b%b%b%b%b expected 1000000000",
               req_ready, mem_valid, mem_we, mem_be, rsp_valid, rsp_fault, busy);
    end
    n_checks++;
    if (rsp_rdata !== 32'd0 || mem_addr !== 32'd0 || mem_wdata !== 32'd0) begin
      n_fail++;
      $display("FAIL reset_data: got %h/%h/%h expected 0/0/0", rsp_rdata, mem_addr, mem_wdata);
    end
    rst_n = 1'b1;
  endtask

  task automatic test_store_lanes();
    logic [31:0] rd, ha, hw; logic f, sm; logic [3:0] hb; int lat;
    run_op(1'b1, 3'b010, 32'h100, 32'hDEADBEEF, 0, 0, rd, f, lat, ha, hb, hw, sm);
    ref_store(3'b010, 32'h100, 32'hDEADBEEF);
    n_checks++;
    if (hb !== 4'b1111 || ha !== 32'h100 || hw !== 32'hDEADBEEF) begin
      n_fail++; $display("FAIL sw_lanes: got %b/%h/%h expected 1111/100/deadbeef", hb, ha, hw);
    end
    n_checks++;
    if (lat !== 2 || f !== 1'b0 || rd !== 32'd0) begin
      n_fail++; $display("FAIL sw_rsp: got lat=%0d fault=%b rdata=%h expected 2/0/0", lat, f, rd);
    end
    run_op(1'b1, 3'b000, 32'h103, 32'h000000AB, 0, 0, rd, f, lat, ha, hb, hw, sm);
    ref_store(3'b000, 32'h103, 32'h000000AB);
    n_checks++;
    if (hb !== 4'b1000 || ha !== 32'h100 || hw !== 32'hABABABAB) begin
      n_fail++; $display("FAIL sb_lanes: got %b/%h/%h expected 1000/100/abababab", hb, ha, hw);
    end
    run_op(1'b1, 3'b001, 32'h106, 32'h1234CAFE, 0, 0, rd, f, lat, ha, hb, hw, sm);
    ref_store(3'b001, 32'h106, 32'h1234CAFE);
    n_checks++;
    if (hb !== 4'b1100 || ha !== 32'h104 || hw !== 32'hCAFECAFE) begin
      n_fail++; $display("FAIL sh_lanes: got %b/%h/%h expected 1100/104/cafecafe", hb, ha, hw);
    end
  endtask

  task automatic test_load_extend();
    logic [31:0] rd, ha, hw; logic f, sm; logic [3:0] hb; int lat;
    logic [2:0]  f3s [6] = '{3'b000, 3'b100, 3'b101, 3'b001, 3'b001, 3'b010};
    logic [31:0] ads [6] = '{32'h102, 32'h102, 32'h102, 32'h102, 32'h100, 32'h100};
    logic [31:0] exp [6] = '{32'hFFFFFFF4, 32'h000000F4, 32'h000012F4,
                             32'h000012F4, 32'h00005678, 32'h12F45678};
    set_word(0, 32'h12F45678);
    for (int i = 0; i < 6; i++) begin
      run_op(1'b0, f3s[i], ads[i], 32'd0, 0, 0, rd, f, lat, ha, hb, hw, sm);
      n_checks++;
      if (rd !== exp[i] || f !== 1'b0 || lat !== 3) begin
        n_fail++;
        $display("FAIL load_ext%0d: got %h fault=%b lat=%0d expected %h/0/3", i, rd, f, lat, exp[i]);
      end
    end
  endtask

  task automatic test_fault_at_accept();
    logic [31:0] rd, ha, hw; logic f, sm; logic [3:0] hb; int lat;
    logic        wes [4] = '{1'b0, 1'b1, 1'b0, 1'b1};
    logic [2:0]  f3s [4] = '{3'b010, 3'b001, 3'b011, 3'b100};
    logic [31:0] ads [4] = '{32'h101, 32'h103, 32'h104, 32'h104};
    for (int i = 0; i < 4; i++) begin
      run_op(wes[i], f3s[i], ads[i], 32'hFFFFFFFF, 0, 0, rd, f, lat, ha, hb, hw, sm);
      n_checks++;
      if (f !== 1'b1 || lat !== 1 || rd !== 32'd0 || sm !== 1'b0) begin
        n_fail++;
        $display("FAIL accept_fault%0d: got fault=%b lat=%0d rdata=%h mem=%b expected 1/1/0/0",
                 i, f, lat, rd, sm);
      end
    end
  endtask

  task automatic test_stall_and_timeout();
    logic [31:0] rd, ha, hw; logic f, sm; logic [3:0] hb; int lat;
    set_word(1, 32'h89ABCDEF);
    run_op(1'b0, 3'b010, 32'h104, 32'd0, 3, 3, rd, f, lat, ha, hb, hw, sm);
    n_checks++;
    if (rd !== 32'h89ABCDEF || f !== 1'b0 || lat !== 9) begin
      n_fail++; $display("FAIL stall_last_cycle: got %h fault=%b lat=%0d expected 89abcdef/0/9", rd, f, lat);
    end
    run_op(1'b0, 3'b010, 32'h104, 32'd0, NEVER, 0, rd, f, lat, ha, hb, hw, sm);
    n_checks++;
    if (rd !== 32'd0 || f !== 1'b1 || lat !== 1 + MAX_WAIT) begin
      n_fail++; $display("FAIL req_timeout: got %h fault=%b lat=%0d expected 0/1/%0d", rd, f, lat, 1 + MAX_WAIT);
    end
    run_op(1'b0, 3'b010, 32'h104, 32'd0, 0, NEVER, rd, f, lat, ha, hb, hw, sm);
    n_checks++;
    if (rd !== 32'd0 || f !== 1'b1 || lat !== 2 + MAX_WAIT) begin
      n_fail++; $display("FAIL wait_timeout: got %h fault=%b lat=%0d expected 0/1/%0d", rd, f, lat, 2 + MAX_WAIT);
    end
    run_op(1'b1, 3'b010, 32'h108, 32'h0BADF00D, NEVER, 0, rd, f, lat, ha, hb, hw, sm);
    n_checks++;
    if (f !== 1'b1 || lat !== 1 + MAX_WAIT) begin
      n_fail++; $display("FAIL store_timeout: got fault=%b lat=%0d expected 1/%0d", f, lat, 1 + MAX_WAIT);
    end
  endtask

  task automatic test_random();
    logic [31:0] rd, ha, hw, addr, wd, exp_rd; logic f, sm, we, ef; logic [3:0] hb;
    logic [2:0] f3; int lat, rdy, rv, exp_lat;
    for (int i = 0; i < 80; i++) begin
      we = 1'($urandom_range(0, 1));
      f3 = 3'($urandom_range(0, 7));
      addr = 32'h100 + 32'($urandom_range(0, 31));
      wd = $urandom;
      rdy = $urandom_range(0, MAX_WAIT - 1);
      rv = $urandom_range(0, MAX_WAIT - 1);
      ef = expect_fault(we, f3, addr);
      exp_rd = (we || ef) ? 32'd0 : ref_load(f3, addr);
      exp_lat = ef ? 1 : (we ? 2 + rdy : 3 + rdy + rv);
      run_op(we, f3, addr, wd, rdy, rv, rd, f, lat, ha, hb, hw, sm);
      if (we && !ef) ref_store(f3, addr, wd);
      n_checks++;
      if (rd !== exp_rd || f !== ef || lat !== exp_lat || sm !== !ef) begin
        n_fail++;
        $display("FAIL random%0d we=%b f3=%0d addr=%h: got %h/%b/lat%0d/mem%b expected %h/%b/lat%0d/mem%b",
                 i, we, f3, addr, rd, f, lat, sm, exp_rd, ef, exp_lat, !ef);
      end
      if (!ef) begin
        n_checks++;
        if (ha !== {addr[31:2], 2'b00}) begin
          n_fail++; $display("FAIL random_addr%0d: got %h expected %h", i, ha, {addr[31:2], 2'b00});
        end
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] rd, ha, hw; logic f, sm; logic [3:0] hb; int lat;
    for (int i = 0; i < 8; i++) begin
      run_op(1'b1, 3'b000, 32'h110 + 32'(i), 32'(8'hA0 + i), 0, 0, rd, f, lat, ha, hb, hw, sm);
      ref_store(3'b000, 32'h110 + 32'(i), 32'(8'hA0 + i));
    end
    for (int i = 0; i < 2; i++) begin
      run_op(1'b0, 3'b010, 32'h110 + 32'(4*i), 32'd0, 0, 0, rd, f, lat, ha, hb, hw, sm);
      n_checks++;
      if (rd !== ref_load(3'b010, 32'h110 + 32'(4*i)) || lat !== 3) begin
        n_fail++;
        $display("FAIL b2b_load%0d: got %h lat=%0d expected %h/3", i, rd, lat,
                 ref_load(3'b010, 32'h110 + 32'(4*i)));
      end
    end
  endtask

  task automatic test_reset_mid_op();
    logic [31:0] rd, ha, hw; logic f, sm; logic [3:0] hb; int lat;
    set_word(2, 32'h5A5A_1234);
    for (int v = 0; v < 2; v++) begin
      @(negedge clk);
      req_valid = 1'b1; req_we = 1'b0; req_funct3 = 3'b010; req_addr = 32'h108;
      mem_ready = 1'b0; mem_rvalid = 1'b0;
      @(negedge clk);
      req_valid = 1'b0;
      if (v == 1) begin
        mem_ready = 1'b1;
        @(negedge clk);
        mem_ready = 1'b0;
      end
      n_checks++;
      if (busy !== 1'b1 || mem_valid !== (v == 0)) begin
        n_fail++; $display("FAIL pre_reset%0d: busy=%b mem_valid=%b expected 1/%b", v, busy, mem_valid, v == 0);
      end
      #2 rst_n = 1'b0;
      #1;
      n_checks++;
      if (busy !== 1'b0 || mem_valid !== 1'b0 || req_ready !== 1'b1 || rsp_valid !== 1'b0) begin
        n_fail++;
        $display("FAIL async_reset%0d: busy=%b mem_valid=%b req_ready=%b rsp_valid=%b expected 0/0/1/0",
                 v, busy, mem_valid, req_ready, rsp_valid);
      end
      for (int k = 0; k < 2; k++) begin
        @(negedge clk);
        n_checks++;
        if (rsp_valid !== 1'b0) begin
          n_fail++; $display("FAIL reset_no_rsp%0d: rsp_valid=%b expected 0", v, rsp_valid);
        end
      end
      rst_n = 1'b1;
      run_op(1'b0, 3'b010, 32'h108, 32'd0, 0, 0, rd, f, lat, ha, hb, hw, sm);
      n_checks++;
      if (rd !== 32'h5A5A1234 || f !== 1'b0 || lat !== 3) begin
        n_fail++; $display("FAIL post_reset%0d: got %h fault=%b lat=%0d expected 5a5a1234/0/3", v, rd, f, lat);
      end
    end
  endtask

  initial begin
    for (int i = 0; i < 8; i++) set_word(i, $urandom);
    test_reset();
    test_store_lanes();
    test_load_extend();
    test_fault_at_accept();
    test_stall_and_timeout();
    test_random();
    test_back_to_back();
    test_reset_mid_op();
    repeat (2) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
